// File: rtl/isa_bus_bridge.sv
// isa_bus_bridge: turns single-cycle CPU bus requests into timed ISA strobe
// cycles (setup / strobe / wait-for-ready / hold) for the CGA card.
// Optional feature macro: ISA_BRIDGE_TIMEOUT_EN. When defined, a strobe held
// low for TIMEOUT cycles is aborted and acked with cpu_timeout=1. When it is
// undefined, the bridge waits for ready indefinitely and cpu_timeout is 0.
`timescale 1ns/1ps
module isa_bus_bridge #(
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned STROBE_MIN    = 8,
    parameter int unsigned HOLD_CYCLES   = 2,
    parameter int unsigned TIMEOUT       = 1023,
    parameter logic [7:0]  OPEN_BUS_DATA = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [19:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_io,
    input  logic        cpu_write,
    output logic        cpu_busy,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_timeout,
    output logic [19:0] bus_a,
    output logic [7:0]  bus_d,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic        bus_aen,
    input  logic [7:0]  bus_in,
    input  logic        bus_dir,
    input  logic        bus_rdy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES);
    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYCLES);
    localparam logic [9:0] STROBE_LAST = 10'(STROBE_MIN);
    localparam logic [9:0] CNT_MAX     = 10'h3FF;

    // Strobe vector order: {ior, iow, memr, memw}, all active low.
    localparam logic [3:0] STRB_NONE = 4'b1111;

    state_t      state_q, state_d;
    logic [3:0]  ph_q, ph_d;          // SETUP / HOLD phase counter
    logic [9:0]  cnt_q, cnt_d;        // saturating strobe-low counter
    logic        io_q, io_d;
    logic        write_q, write_d;
    logic [19:0] bus_a_q, bus_a_d;
    logic [7:0]  bus_d_q, bus_d_d;
    logic [3:0]  strb_l_q, strb_l_d;
    logic        aen_q, aen_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic [7:0]  rdata_q, rdata_d;
`ifdef ISA_BRIDGE_TIMEOUT_EN
    logic        timeout_q, timeout_d;
`endif

    logic        rdy_meta_q, rdy_sync_q;
    logic        rdy_s;
    logic [9:0]  cnt_inc_s;
    logic        timeout_hit_s;
    logic [3:0]  strb_sel_s;
    logic [7:0]  read_data_s;

    assign rdy_s = rdy_sync_q;

    // Two-flop synchronizer for the card's asynchronous ready line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_meta_q <= 1'b1;
            rdy_sync_q <= 1'b1;
        end else begin
            rdy_meta_q <= bus_rdy;
            rdy_sync_q <= rdy_meta_q;
        end
    end

    // Helper terms: saturating count, abort condition, strobe select, read data.
    always_comb begin
        cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + 10'd1);
`ifdef ISA_BRIDGE_TIMEOUT_EN
        timeout_hit_s = (cnt_q == 10'(TIMEOUT));
`else
        timeout_hit_s = 1'b0;
`endif
        case ({io_q, write_q})
            2'b10:   strb_sel_s = 4'b0111;   // IO read
            2'b11:   strb_sel_s = 4'b1011;   // IO write
            2'b00:   strb_sel_s = 4'b1101;   // memory read
            2'b01:   strb_sel_s = 4'b1110;   // memory write
            default: strb_sel_s = STRB_NONE;
        endcase
        if (bus_dir) begin
            read_data_s = bus_in;
        end else begin
            read_data_s = OPEN_BUS_DATA;
        end
    end

    // Next-state and next-output logic for the bus cycle sequencer.
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        cnt_d    = cnt_q;
        io_d     = io_q;
        write_d  = write_q;
        bus_a_d  = bus_a_q;
        bus_d_d  = bus_d_q;
        strb_l_d = strb_l_q;
        aen_d    = aen_q;
        busy_d   = busy_q;
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
`ifdef ISA_BRIDGE_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    bus_a_d = cpu_addr;
                    bus_d_d = cpu_wdata;
                    io_d    = cpu_io;
                    write_d = cpu_write;
                    aen_d   = 1'b0;
                    busy_d  = 1'b1;
                    ph_d    = 4'd1;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (ph_q == SETUP_LAST) begin
                    strb_l_d = strb_sel_s;
                    cnt_d    = 10'd1;
                    state_d  = ST_STROBE;
                end else begin
                    ph_d = ph_q + 4'd1;
                end
            end
            ST_STROBE: begin
                if (timeout_hit_s) begin
                    strb_l_d = STRB_NONE;
                    ph_d     = 4'd1;
                    state_d  = ST_HOLD;
                    if (!write_q) begin
                        rdata_d = OPEN_BUS_DATA;
                    end else begin
                        rdata_d = rdata_q;
                    end
`ifdef ISA_BRIDGE_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                end else if (cnt_q == STROBE_LAST) begin
                    cnt_d   = cnt_inc_s;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_WAIT: begin
                // Ready wins over a coincident timeout: the card did answer.
                if (rdy_s) begin
                    strb_l_d = STRB_NONE;
                    ph_d     = 4'd1;
                    state_d  = ST_HOLD;
                    if (!write_q) begin
                        rdata_d = read_data_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
`ifdef ISA_BRIDGE_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end else if (timeout_hit_s) begin
                    strb_l_d = STRB_NONE;
                    ph_d     = 4'd1;
                    state_d  = ST_HOLD;
                    if (!write_q) begin
                        rdata_d = OPEN_BUS_DATA;
                    end else begin
                        rdata_d = rdata_q;
                    end
`ifdef ISA_BRIDGE_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_HOLD: begin
                if (ph_q == HOLD_LAST) begin
                    ack_d   = 1'b1;
                    aen_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    ph_d = ph_q + 4'd1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                strb_l_d = STRB_NONE;
                aen_d    = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops; reset releases the bus at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ph_q     <= 4'd0;
            cnt_q    <= 10'd0;
            io_q     <= 1'b0;
            write_q  <= 1'b0;
            bus_a_q  <= 20'd0;
            bus_d_q  <= 8'd0;
            strb_l_q <= STRB_NONE;
            aen_q    <= 1'b1;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= 8'd0;
`ifdef ISA_BRIDGE_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            cnt_q    <= cnt_d;
            io_q     <= io_d;
            write_q  <= write_d;
            bus_a_q  <= bus_a_d;
            bus_d_q  <= bus_d_d;
            strb_l_q <= strb_l_d;
            aen_q    <= aen_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
`ifdef ISA_BRIDGE_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    assign cpu_busy   = busy_q;
    assign cpu_ack    = ack_q;
    assign cpu_rdata  = rdata_q;
`ifdef ISA_BRIDGE_TIMEOUT_EN
    assign cpu_timeout = timeout_q;
`else
    assign cpu_timeout = 1'b0;
`endif
    assign bus_a      = bus_a_q;
    assign bus_d      = bus_d_q;
    assign bus_ior_l  = strb_l_q[3];
    assign bus_iow_l  = strb_l_q[2];
    assign bus_memr_l = strb_l_q[1];
    assign bus_memw_l = strb_l_q[0];
    assign bus_aen    = aen_q;

endmodule

// File: tb/tb_isa_bus_bridge.sv
// Scoreboard bench for isa_bus_bridge: stimulus pushes expected cycles,
// a negedge monitor measures each bus cycle and compares at cpu_ack.
`timescale 1ns/1ps
module tb_isa_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [19:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_io;
    logic        cpu_write;
    logic        cpu_busy;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_timeout;
    logic [19:0] bus_a;
    logic [7:0]  bus_d;
    logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l;
    logic        bus_aen;
    logic [7:0]  bus_in;
    logic        bus_dir;
    logic        bus_rdy;

    always #5 clk = ~clk;

    isa_bus_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_io     (cpu_io),
        .cpu_write  (cpu_write),
        .cpu_busy   (cpu_busy),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .cpu_timeout(cpu_timeout),
        .bus_a      (bus_a),
        .bus_d      (bus_d),
        .bus_ior_l  (bus_ior_l),
        .bus_iow_l  (bus_iow_l),
        .bus_memr_l (bus_memr_l),
        .bus_memw_l (bus_memw_l),
        .bus_aen    (bus_aen),
        .bus_in     (bus_in),
        .bus_dir    (bus_dir),
        .bus_rdy    (bus_rdy)
    );

    // {ior, iow, memr, memw}
    wire [3:0] strb_l = {bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l};

    typedef struct {
        logic [3:0]  mask;
        logic [19:0] addr;
        logic [7:0]  wdata;
        logic        write;
        int          low;
        logic [7:0]  rdata;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int n_push = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] mask, input logic [19:0] addr, input logic [7:0] wdata,
                        input logic write, input int low, input logic [7:0] rdata, input logic to);
        exp_t e;
        e.mask = mask; e.addr = addr; e.wdata = wdata; e.write = write;
        e.low = low; e.rdata = rdata; e.to = to;
        exp_q.push_back(e);
        n_push++;
    endtask

    // Monitor: measures setup/low/hold lengths and bus stability, checks at ack.
    initial begin : monitor
        int m_setup, m_low, m_hold;
        logic [3:0] m_mask;
        logic m_seen, m_bad_a, m_bad_d, busy_chk;
        exp_t e;
        m_setup = 0; m_low = 0; m_hold = 0; m_mask = 4'd0;
        m_seen = 1'b0; m_bad_a = 1'b0; m_bad_d = 1'b0; busy_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                m_setup = 0; m_low = 0; m_hold = 0; m_mask = 4'd0;
                m_seen = 1'b0; m_bad_a = 1'b0; m_bad_d = 1'b0; busy_chk = 1'b0;
            end else begin
                if (busy_chk) begin
                    chk("busy_after_ack", {31'd0, cpu_busy}, 32'd0);
                    busy_chk = 1'b0;
                end
                if (bus_aen === 1'b0) begin
                    if (~strb_l != 4'd0) begin
                        m_low++;
                        m_mask = m_mask | ~strb_l;
                        m_seen = 1'b1;
                    end else if (m_seen) begin
                        m_hold++;
                    end else begin
                        m_setup++;
                    end
                    if (exp_q.size() > 0) begin
                        if (bus_a !== exp_q[0].addr) m_bad_a = 1'b1;
                        if (exp_q[0].write && (bus_d !== exp_q[0].wdata)) m_bad_d = 1'b1;
                    end
                end
                if (cpu_ack === 1'b1) begin
                    ack_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack: got ack, expected none");
                    end else begin
                        e = exp_q.pop_front();
                        chk("strobe_select", {28'd0, m_mask}, {28'd0, e.mask});
                        chk("setup_cycles", m_setup, 2);
                        chk("strobe_low_cycles", m_low, e.low);
                        chk("hold_cycles", m_hold, 2);
                        chk("bus_a_stable", {31'd0, m_bad_a}, 32'd0);
                        chk("bus_d_stable", {31'd0, m_bad_d}, 32'd0);
                        chk("rdata", {24'd0, cpu_rdata}, {24'd0, e.rdata});
                        chk("timeout_flag", {31'd0, cpu_timeout}, {31'd0, e.to});
                        chk("busy_at_ack", {31'd0, cpu_busy}, 32'd1);
                        chk("aen_at_ack", {31'd0, bus_aen}, 32'd1);
                    end
                    m_setup = 0; m_low = 0; m_hold = 0; m_mask = 4'd0;
                    m_seen = 1'b0; m_bad_a = 1'b0; m_bad_d = 1'b0; busy_chk = 1'b1;
                end
            end
        end
    end

    // Single-cycle request pulse; called at a negedge while the bridge is idle.
    task automatic issue(input logic io, input logic write, input logic [19:0] a, input logic [7:0] d);
        cpu_io = io; cpu_write = write; cpu_addr = a; cpu_wdata = d;
        cpu_req = 1'b1;
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (cpu_busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL %s: busy still %0b, expected 0 within 3000 cycles", name, cpu_busy);
        end
    endtask

    task automatic wait_strobe(input string name, input int idx, input logic lvl);
        int n = 0;
        while (strb_l[idx] !== lvl && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++; errors++;
            $display("FAIL %s: strobe %0d got %0b expected %0b", name, idx, strb_l[idx], lvl);
        end
    endtask

    initial begin : stim
        int n;
        int acks_before;
        reset = 1'b1; cpu_req = 1'b0; cpu_addr = 20'd0; cpu_wdata = 8'd0;
        cpu_io = 1'b0; cpu_write = 1'b0; bus_in = 8'd0; bus_dir = 1'b0; bus_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_strobes", {28'd0, strb_l}, 32'hF);
        chk("reset_aen", {31'd0, bus_aen}, 32'd1);
        chk("reset_bus_a", {12'd0, bus_a}, 32'd0);
        chk("reset_bus_d", {24'd0, bus_d}, 32'd0);
        chk("reset_busy", {31'd0, cpu_busy}, 32'd0);
        chk("reset_ack", {31'd0, cpu_ack}, 32'd0);
        chk("reset_rdata", {24'd0, cpu_rdata}, 32'd0);
        chk("reset_timeout", {31'd0, cpu_timeout}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // IO write, card ready: low = STROBE_MIN + 1, rdata untouched (0).
        push(4'b0100, 20'h003D8, 8'h29, 1'b1, 9, 8'h00, 1'b0);
        issue(1'b1, 1'b1, 20'h003D8, 8'h29);
        wait_idle("io_write_done");

        // Memory read with ready low for 20 cycles after memr_l falls.
        bus_rdy = 1'b0; bus_in = 8'h41; bus_dir = 1'b1;
        repeat (3) @(negedge clk);
        push(4'b0010, 20'hB8000, 8'h00, 1'b0, 23, 8'h41, 1'b0);
        issue(1'b0, 1'b0, 20'hB8000, 8'h00);
        wait_strobe("memr_fall", 1, 1'b0);
        repeat (20) @(negedge clk);
        bus_rdy = 1'b1;
        wait_idle("mem_read_done");

        // IO read with the card not driving: open bus.
        bus_in = 8'h5A; bus_dir = 1'b0;
        push(4'b1000, 20'h003DA, 8'h00, 1'b0, 9, 8'hFF, 1'b0);
        issue(1'b1, 1'b0, 20'h003DA, 8'h00);
        wait_idle("io_read_done");

        // Memory write: rdata keeps FF.
        push(4'b0001, 20'hB8001, 8'h55, 1'b1, 9, 8'hFF, 1'b0);
        issue(1'b0, 1'b1, 20'hB8001, 8'h55);
        wait_idle("mem_write_done");

        // Requests in SETUP and HOLD are ignored; request in first IDLE accepted.
        push(4'b0100, 20'h003D9, 8'h12, 1'b1, 9, 8'hFF, 1'b0);
        issue(1'b1, 1'b1, 20'h003D9, 8'h12);
        cpu_io = 1'b0; cpu_write = 1'b0; cpu_addr = 20'h12345; cpu_wdata = 8'hAA;
        cpu_req = 1'b1;
        @(negedge clk);
        cpu_req = 1'b0;
        wait_strobe("iow_fall", 2, 1'b0);
        wait_strobe("iow_rise", 2, 1'b1);
        cpu_req = 1'b1;
        @(negedge clk);
        cpu_req = 1'b0;
        n = 0;
        while (cpu_ack !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL ack_wait: ack %0b expected 1 within 100 cycles", cpu_ack);
        end
        bus_in = 8'h7E; bus_dir = 1'b1;
        push(4'b0010, 20'hB8002, 8'h00, 1'b0, 9, 8'h7E, 1'b0);
        cpu_io = 1'b0; cpu_write = 1'b0; cpu_addr = 20'hB8002; cpu_wdata = 8'h00;
        cpu_req = 1'b1;
        repeat (2) @(negedge clk);
        cpu_req = 1'b0;
        wait_idle("back_to_back_done");

        // Card never ready on a memory read.
        bus_rdy = 1'b0;
        repeat (3) @(negedge clk);
`ifdef ISA_BRIDGE_TIMEOUT_EN
        push(4'b0010, 20'hC0000, 8'h00, 1'b0, 1023, 8'hFF, 1'b1);
        issue(1'b0, 1'b0, 20'hC0000, 8'h00);
        wait_idle("timeout_done");
        bus_rdy = 1'b1;
`else
        acks_before = ack_cnt;
        issue(1'b0, 1'b0, 20'hC0000, 8'h00);
        repeat (5000) @(negedge clk);
        chk("no_ack_without_rdy", ack_cnt, acks_before);
        chk("still_busy", {31'd0, cpu_busy}, 32'd1);
        chk("memr_still_low", {31'd0, bus_memr_l}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus_rdy = 1'b1;
`endif
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of an IO write strobe.
        issue(1'b1, 1'b1, 20'h003D8, 8'h77);
        wait_strobe("iow_fall_rst", 2, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_iow_high", {31'd0, bus_iow_l}, 32'd1);
        chk("rst_aen_high", {31'd0, bus_aen}, 32'd1);
        chk("rst_busy_low", {31'd0, cpu_busy}, 32'd0);
        chk("rst_bus_a", {12'd0, bus_a}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Normal cycles after reset: rdata back to 0, then a driven IO read.
        push(4'b0100, 20'h003D9, 8'h01, 1'b1, 9, 8'h00, 1'b0);
        issue(1'b1, 1'b1, 20'h003D9, 8'h01);
        wait_idle("post_rst_write");
        bus_in = 8'h3C; bus_dir = 1'b1;
        push(4'b1000, 20'h003DA, 8'h00, 1'b0, 9, 8'h3C, 1'b0);
        issue(1'b1, 1'b0, 20'h003DA, 8'h00);
        wait_idle("post_rst_read");
        repeat (3) @(negedge clk);

        chk("ack_count", ack_cnt, n_push);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
